rv32i_trace_buffer: RTL
=======================

Name: rv32i_trace_buffer

Overview:
- Synthesizable run-control and instruction-trace capture unit sitting beside the rv32i core.
- Records each fetched instruction (PC plus instruction word) into a circular buffer while running.
- Stops capture on an invalid fetch, a halt sentinel instruction, or a cycle limit.
- After stopping, streams the captured trace oldest-first over a valid/ready port for a host or debug link.

Parameters:
- ADDR_W, 16, instruction address width.
- DATA_W, 32, instruction word width.
- DEPTH, 64, trace entries; power of two, ≥2.
- MAX_CYCLES, 64, RUN cycles before forced halt; ≥1.
- CNT_W, 16, cycle counter width; must satisfy 2^CNT_W > MAX_CYCLES.
- HALT_INSTR, 32'h0000_0073, sentinel instruction (ecall) that ends a run.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a run from IDLE.
- instr_valid  in  1  core presents a valid fetch this cycle.
- instr_addr  in  ADDR_W  PC of the fetch.
- instruction  in  DATA_W  fetched word.
- running  out  1  high in RUN.
- halt_cause  out  2  0 none, 1 cycle limit, 2 invalid fetch, 3 sentinel.
- cycle_count  out  CNT_W  RUN cycles elapsed.
- entry_count  out  $clog2(DEPTH)+1  entries held; saturates at DEPTH.
- overflow  out  1  oldest entries were overwritten.
- rd_valid  out  1  trace entry available.
- rd_ready  in  1  consumer accepts entry.
- rd_addr  out  ADDR_W  entry PC.
- rd_instr  out  DATA_W  entry instruction.
- rd_last  out  1  final entry of the dump.

Behaviour:
- States: IDLE, RUN, DRAIN.
- Reset (async, rst_n=0):
  - state IDLE; all pointers and counters 0.
  - running, halt_cause, cycle_count, entry_count, overflow, rd_valid, rd_last all 0; rd_addr, rd_instr 0.
  - Reset mid-RUN or mid-DRAIN discards the run.
- IDLE:
  - start=1 clears pointers, cycle_count, entry_count, overflow, halt_cause; enters RUN next cycle.
  - The start cycle itself captures nothing.
  - Results of the previous run hold until the next start.
- RUN: each cycle cycle_count += 1, then exactly one of the following, in priority order:
  - instr_valid=0: nothing written; halt_cause=2; go to DRAIN.
  - instr_valid=1 and instruction==HALT_INSTR: entry written; halt_cause=3; go to DRAIN.
  - instr_valid=1 and cycle_count (pre-increment) == MAX_CYCLES-1: entry written; halt_cause=1; go to DRAIN.
  - Otherwise: entry written, stay in RUN.
  - Priority: invalid > sentinel > limit (a sentinel on the last allowed cycle reports 3).
- Write rules:
  - Entry {instr_addr, instruction} is stored at wr_ptr; wr_ptr increments mod DEPTH (wrap-around).
  - If entry_count==DEPTH, the write overwrites the oldest entry and sets overflow=1 (sticky for the run).
  - Otherwise entry_count += 1.
- running=1 exactly in RUN. start is ignored in RUN and DRAIN.
- DRAIN:
  - rd_ptr initialises to wr_ptr if overflow, else 0.
  - rd_valid=1 while entries remain; rd_addr/rd_instr show the entry at rd_ptr.
  - A transfer happens when rd_valid and rd_ready are both 1; rd_ptr then increments mod DEPTH.
  - rd_last=1 together with rd_valid on the final entry (remaining==1).
  - With rd_valid=1 and rd_ready=0, rd_addr, rd_instr and rd_last stay stable.
  - After the last transfer, next cycle: rd_valid=0 and state IDLE.
  - entry_count==0 at entry (immediate invalid fetch): rd_valid never asserts; IDLE next cycle.
- entry_count reports the captured total; it does not decrement during the drain.
- rd_addr/rd_instr are don't-care when rd_valid=0.
- Storage: register array or inferred RAM with a same-cycle read path for rd data. Write and read never overlap (disjoint states).

Test Plan:
- Normal run: start; 5 valid fetches at PCs 0x0,0x4,…,0x10; then instr_valid=0 → halt_cause=2, cycle_count=6, entry_count=5, overflow=0; drain returns the 5 entries in order with rd_last on the 5th; IDLE afterwards.
- Cycle limit: DEPTH=64, MAX_CYCLES=64, continuous valid non-sentinel fetches → halt after 64 RUN cycles, halt_cause=1, entry_count=64, overflow=0; 64 entries drained.
- Wrap-around: DEPTH=8, 12 valid fetches (PC=4*i), then invalid → overflow=1, entry_count=8; drain yields PCs 0x10..0x2C in order.
- Sentinel: 3rd fetch is 0x00000073, asserted also on the MAX_CYCLES-1 cycle in a second run → halt_cause=3 both times; the sentinel entry is included (3 entries in the first run).
- Backpressure: rd_ready random at 50% → no lost or duplicated entries; data stable while stalled; start pulses during DRAIN are ignored.
- Reset mid-RUN after 4 captures: rst_n low asynchronously → all outputs 0 immediately, state IDLE; a subsequent start produces a clean new run.

Source files
------------

// File: rtl/rv32i_trace_buffer_if.sv
// Trace read-out stream: the buffer is the master (source), the host/debug link is the slave (sink).
interface rv32i_trace_buffer_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_instr;
    logic              rd_last;

    modport master (
        output rd_valid, rd_addr, rd_instr, rd_last,
        input  rd_ready
    );

    modport slave (
        input  rd_valid, rd_addr, rd_instr, rd_last,
        output rd_ready
    );
endinterface

// File: rtl/rv32i_trace_buffer.sv
// Run-control and instruction-trace capture: records {PC, instr} per fetch into a circular
// buffer during RUN, then streams the trace oldest-first over a valid/ready port in DRAIN.
module rv32i_trace_buffer #(
    parameter int                ADDR_W     = 16,
    parameter int                DATA_W     = 32,
    parameter int                DEPTH      = 64,
    parameter int                MAX_CYCLES = 64,
    parameter int                CNT_W      = 16,
    parameter logic [DATA_W-1:0] HALT_INSTR = 'h0000_0073
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     instr_valid,
    input  logic [ADDR_W-1:0]        instr_addr,
    input  logic [DATA_W-1:0]        instruction,
    output logic                     running,
    output logic [1:0]               halt_cause,
    output logic [CNT_W-1:0]         cycle_count,
    output logic [$clog2(DEPTH):0]   entry_count,
    output logic                     overflow,
    rv32i_trace_buffer_if.master     rd
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int EW    = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_e;

    state_e                     state_q;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q;
    logic [EW-1:0]              entry_q, entry_d;
    logic [EW-1:0]              remain_q;
    logic [CNT_W-1:0]           cycle_q;
    logic                       ovf_q, ovf_d;
    logic [1:0]                 cause_q;
    logic                       running_q;
    logic                       rd_valid_q;
    logic                       rd_last_q;
    logic [ADDR_W+DATA_W-1:0]   mem_q [DEPTH];
    logic [ADDR_W+DATA_W-1:0]   rd_entry;
    logic                       wr_en;
    logic                       is_halt;
    logic                       at_limit;
    logic                       stop;

    always_comb begin
        wr_en    = (state_q == S_RUN) && instr_valid;
        is_halt  = (instruction == HALT_INSTR);
        at_limit = (cycle_q == CNT_W'(MAX_CYCLES - 1));
        stop     = !instr_valid || is_halt || at_limit;
        wr_ptr_d = wr_ptr_q;
        entry_d  = entry_q;
        ovf_d    = ovf_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            // A full buffer overwrites its oldest slot instead of growing.
            if (entry_q == EW'(DEPTH)) begin
                ovf_d = 1'b1;
            end else begin
                entry_d = entry_q + EW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {instr_addr, instruction};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            entry_q    <= '0;
            remain_q   <= '0;
            cycle_q    <= '0;
            ovf_q      <= 1'b0;
            cause_q    <= 2'd0;
            running_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q   <= S_RUN;
                        wr_ptr_q  <= '0;
                        rd_ptr_q  <= '0;
                        entry_q   <= '0;
                        cycle_q   <= '0;
                        ovf_q     <= 1'b0;
                        cause_q   <= 2'd0;
                        running_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    cycle_q  <= cycle_q + CNT_W'(1);
                    wr_ptr_q <= wr_ptr_d;
                    entry_q  <= entry_d;
                    ovf_q    <= ovf_d;
                    if (stop) begin
                        state_q   <= S_DRAIN;
                        running_q <= 1'b0;
                        cause_q   <= !instr_valid ? 2'd2 : (is_halt ? 2'd3 : 2'd1);
                        // After a wrap the oldest surviving entry sits at the write pointer.
                        rd_ptr_q   <= ovf_d ? wr_ptr_d : '0;
                        remain_q   <= entry_d;
                        rd_valid_q <= (entry_d != '0);
                        rd_last_q  <= (entry_d == EW'(1));
                    end
                end
                S_DRAIN: begin
                    if (!rd_valid_q) begin
                        state_q <= S_IDLE;
                    end else if (rd.rd_ready) begin
                        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                        remain_q <= remain_q - EW'(1);
                        if (remain_q == EW'(1)) begin
                            rd_valid_q <= 1'b0;
                            rd_last_q  <= 1'b0;
                            state_q    <= S_IDLE;
                        end else begin
                            rd_last_q <= (remain_q == EW'(2));
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rd_entry    = mem_q[rd_ptr_q];
    assign rd.rd_valid = rd_valid_q;
    assign rd.rd_last  = rd_last_q;
    assign rd.rd_addr  = rd_valid_q ? rd_entry[ADDR_W+DATA_W-1:DATA_W] : '0;
    assign rd.rd_instr = rd_valid_q ? rd_entry[DATA_W-1:0] : '0;

    assign running     = running_q;
    assign halt_cause  = cause_q;
    assign cycle_count = cycle_q;
    assign entry_count = entry_q;
    assign overflow    = ovf_q;

endmodule
